vga_vram_arbiter: RTL and testbench

- Shares one synchronous single-port video RAM between the VGA pixel fetch path and AHB-Lite slave writes from the CPU.
- Pixel reads have absolute priority and a fixed latency. CPU writes are buffered in a small FIFO and drained into free RAM slots.
- Sits between the AHB VGA slave, the VGA timing/pixel pipeline and the VRAM inside AHBLITE_SYS.

---
 rtl/vga_vram_arbiter_if.sv | 37 +++
 rtl/vga_vram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_vga_vram_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its neighbours: the pixel fetch
// path, the CPU write path, the single-port VRAM and the status signals.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface vga_vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  wbuf_count;
  logic              starve_err;
  logic              err_clr;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata, err_clr,
    output pix_data, pix_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata,
           wbuf_count, starve_err
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata, err_clr,
    input  pix_data, pix_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata,
           wbuf_count, starve_err
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Arbiter for one single-port VRAM shared by the VGA pixel fetch path and
// CPU writes. Pixel reads always win the slot and see a fixed latency; CPU
// writes are buffered in a small FIFO and drained into otherwise idle slots.
// A FIFO entry becomes eligible for a write slot two edges after its push, so
// a freshly pushed entry never competes in the edge right after it arrived.
// A sticky flag reports when a non-empty FIFO is starved by reads for too long.
module vga_vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int WBUF_DEPTH = 4,
  parameter int STARVE_MAX = 64
) (
  input logic                CLK,
  input logic                RESET,
  vga_vram_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(WBUF_DEPTH);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);

  // write buffer storage and bookkeeping
  logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] fifo_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  eligible;
  logic              pushed_last;
  logic              wr_ready_q;

  // slot decision
  logic              push;
  logic              do_read;
  logic              do_write;

  // RAM port and read return pipeline
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              rd_d1;
  logic              pix_valid_q;
  logic [DATA_W-1:0] pix_data_q;

  // starvation monitor
  logic [STV_W-1:0]  starve_cnt;
  logic              starve_set;
  logic              starve_err_q;

  // Slot arbitration, FIFO occupancy update and starvation set condition
  always_comb begin
    push       = bus.wr_valid & wr_ready_q;
    eligible   = count - {{(CNT_W-1){1'b0}}, pushed_last};
    do_read    = bus.rd_req;
    do_write   = ~bus.rd_req & (eligible != {CNT_W{1'b0}});
    count_next = count;
    case ({push, do_write})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
    if (do_read && (count != {CNT_W{1'b0}}) && (starve_cnt == STARVE_C - STV_W'(1))) begin
      starve_set = 1'b1;
    end else begin
      starve_set = 1'b0;
    end
  end

  // Write FIFO: push at the tail, pop the head when a write slot is granted
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr      <= {PTR_W{1'b0}};
      rd_ptr      <= {PTR_W{1'b0}};
      count       <= {CNT_W{1'b0}};
      pushed_last <= 1'b0;
      wr_ready_q  <= 1'b0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        fifo_addr[i] <= {ADDR_W{1'b0}};
        fifo_data[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= bus.wr_addr;
        fifo_data[wr_ptr] <= bus.wr_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (do_write) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count       <= count_next;
      pushed_last <= push;
      // ready depends only on registered occupancy: no bypass through a pop
      wr_ready_q  <= (count_next < DEPTH_C);
    end
  end

  // RAM port registers: read, buffered write or idle (address/data hold)
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= {ADDR_W{1'b0}};
      ram_wdata_q <= {DATA_W{1'b0}};
    end else if (do_read) begin
      ram_en_q   <= 1'b1;
      ram_we_q   <= 1'b0;
      ram_addr_q <= bus.rd_addr;
    end else if (do_write) begin
      ram_en_q    <= 1'b1;
      ram_we_q    <= 1'b1;
      ram_addr_q  <= fifo_addr[rd_ptr];
      ram_wdata_q <= fifo_data[rd_ptr];
    end else begin
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
    end
  end

  // Read return pipeline: RAM access cycle, RAM data cycle, pixel register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_d1       <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= {DATA_W{1'b0}};
    end else begin
      rd_d1       <= ram_en_q & ~ram_we_q;
      pix_valid_q <= rd_d1;
      if (rd_d1) begin
        pix_data_q <= bus.ram_rdata;
      end
    end
  end

  // Starvation counter and sticky error flag (a coincident set beats a clear)
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_cnt   <= {STV_W{1'b0}};
      starve_err_q <= 1'b0;
    end else begin
      if ((count == {CNT_W{1'b0}}) || do_write) begin
        starve_cnt <= {STV_W{1'b0}};
      end else if (do_read && (starve_cnt != STARVE_C)) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
      if (starve_set) begin
        starve_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        starve_err_q <= 1'b0;
      end
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign bus.ram_en     = ram_en_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.wbuf_count = count;
  assign bus.starve_err = starve_err_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: a behavioural single-port RAM answers
// the arbiter, inputs change on the falling edge, outputs are checked there.
module tb_vga_vram_arbiter;

  logic CLK = 1'b0;
  logic RESET;
  int   tests  = 0;
  int   failed = 0;

  vga_vram_arbiter_if bus ();

  vga_vram_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // behavioural VRAM: written words remembered, others return fixed content
  logic [7:0] mem     [0:65535];
  logic       written [0:65535];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    case (a)
      16'h0123: init_val = 8'h1C;
      16'h0100: init_val = 8'h5A;
      16'h0104: init_val = 8'hA5;
      default:  init_val = a[7:0] ^ 8'h3C;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (bus.ram_en === 1'b1) begin
      if (bus.ram_we === 1'b1) begin
        mem[bus.ram_addr]     <= bus.ram_wdata;
        written[bus.ram_addr] <= 1'b1;
      end else begin
        bus.ram_rdata <= (written[bus.ram_addr] === 1'b1) ? mem[bus.ram_addr]
                                                          : init_val(bus.ram_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_slot(input string tag, input logic en, input logic we,
                            input logic [15:0] addr, input logic [7:0] data);
    check({tag, "_en"}, 32'(bus.ram_en), 32'(en));
    check({tag, "_we"}, 32'(bus.ram_we), 32'(we));
    check({tag, "_addr"}, 32'(bus.ram_addr), 32'(addr));
    if (we) begin
      check({tag, "_wdata"}, 32'(bus.ram_wdata), 32'(data));
    end else begin
      check({tag, "_nowdata"}, 32'(bus.ram_we), 32'(1'b0));
    end
  endtask

  initial begin
    bus.rd_req   = 1'b0;
    bus.rd_addr  = 16'h0000;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 16'h0000;
    bus.wr_data  = 8'h00;
    bus.err_clr  = 1'b0;
    RESET        = 1'b0;
    #1 RESET     = 1'b1;
    #1;

    // ---- reset state ----
    check("rst_wr_ready",   32'(bus.wr_ready),   32'd0);
    check("rst_ram_en",     32'(bus.ram_en),     32'd0);
    check("rst_ram_we",     32'(bus.ram_we),     32'd0);
    check("rst_ram_addr",   32'(bus.ram_addr),   32'd0);
    check("rst_pix_valid",  32'(bus.pix_valid),  32'd0);
    check("rst_pix_data",   32'(bus.pix_data),   32'd0);
    check("rst_count",      32'(bus.wbuf_count), 32'd0);
    check("rst_starve_err", 32'(bus.starve_err), 32'd0);

    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rel_wr_ready_before_edge", 32'(bus.wr_ready), 32'd0);
    @(negedge CLK);
    check("rel_wr_ready_after_edge", 32'(bus.wr_ready), 32'd1);
    check("rel_ram_en", 32'(bus.ram_en), 32'd0);
    check("rel_count",  32'(bus.wbuf_count), 32'd0);

    // ---- single read: latency of three edges ----
    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'h0123;
    step();
    check_slot("rd1_slot", 1'b1, 1'b0, 16'h0123, 8'h00);
    check("rd1_pv_c1", 32'(bus.pix_valid), 32'd0);
    bus.rd_req = 1'b0;
    step();
    check("rd1_pv_c2", 32'(bus.pix_valid), 32'd0);
    check("rd1_idle_en", 32'(bus.ram_en), 32'd0);
    step();
    check("rd1_pv_c3", 32'(bus.pix_valid), 32'd1);
    check("rd1_pix",   32'(bus.pix_data),  32'h1C);
    step();
    check("rd1_pv_c4", 32'(bus.pix_valid), 32'd0);

    // ---- write drain: counts 1,2,2,1,0 ----
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 16'h0010;
    bus.wr_data  = 8'hAA;
    step();
    check("wd_count1", 32'(bus.wbuf_count), 32'd1);
    check("wd_idle1",  32'(bus.ram_en), 32'd0);
    bus.wr_addr = 16'h0011;
    bus.wr_data = 8'hBB;
    step();
    check("wd_count2", 32'(bus.wbuf_count), 32'd2);
    check("wd_idle2",  32'(bus.ram_en), 32'd0);
    bus.wr_addr = 16'h0012;
    bus.wr_data = 8'hCC;
    step();
    check("wd_count3", 32'(bus.wbuf_count), 32'd2);
    check_slot("wd_w0", 1'b1, 1'b1, 16'h0010, 8'hAA);
    bus.wr_valid = 1'b0;
    step();
    check("wd_count4", 32'(bus.wbuf_count), 32'd1);
    check_slot("wd_w1", 1'b1, 1'b1, 16'h0011, 8'hBB);
    step();
    check("wd_count5", 32'(bus.wbuf_count), 32'd0);
    check_slot("wd_w2", 1'b1, 1'b1, 16'h0012, 8'hCC);
    step();
    check("wd_idle_en",   32'(bus.ram_en),   32'd0);
    check("wd_idle_hold", 32'(bus.ram_addr), 32'h0012);
    check("wd_ready",     32'(bus.wr_ready), 32'd1);

    // ---- full FIFO under continuous reads ----
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 16'h0200;
    bus.wr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.wr_addr = 16'h0040 + 16'(k);
      bus.wr_data = 8'h50 + 8'(k);
      step();
      check("full_count", 32'(bus.wbuf_count), 32'(k + 1));
      check("full_rd_slot", 32'(bus.ram_we), 32'd0);
    end
    check("full_ready_low", 32'(bus.wr_ready), 32'd0);
    bus.wr_addr = 16'h0044;
    bus.wr_data = 8'h54;
    step();
    check("full_reject_count", 32'(bus.wbuf_count), 32'd4);
    check("full_reject_ready", 32'(bus.wr_ready), 32'd0);
    bus.rd_req = 1'b0;
    step();
    check("full_nobypass_count", 32'(bus.wbuf_count), 32'd3);
    check("full_ready_back", 32'(bus.wr_ready), 32'd1);
    check_slot("full_d0", 1'b1, 1'b1, 16'h0040, 8'h50);
    bus.wr_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      check_slot("full_d", 1'b1, 1'b1, 16'h0040 + 16'(k), 8'h50 + 8'(k));
      check("full_drain_count", 32'(bus.wbuf_count), 32'(3 - k));
    end
    step();
    check("full_done_en", 32'(bus.ram_en), 32'd0);

    // ---- priority and pipelining: reads every 4 slots, writes between ----
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 16'h0300;
    bus.wr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.wr_addr = 16'h0020 + 16'(k);
      bus.wr_data = 8'h31 + 8'(k);
      step();
    end
    bus.wr_valid = 1'b0;
    check("pri_fill_count", 32'(bus.wbuf_count), 32'd4);
    bus.rd_addr = 16'h0100;
    step();
    check_slot("pri_r0", 1'b1, 1'b0, 16'h0100, 8'h00);
    bus.rd_req = 1'b0;
    step();
    check_slot("pri_w0", 1'b1, 1'b1, 16'h0020, 8'h31);
    step();
    check_slot("pri_w1", 1'b1, 1'b1, 16'h0021, 8'h32);
    check("pri_pv0", 32'(bus.pix_valid), 32'd1);
    check("pri_pix0", 32'(bus.pix_data), 32'h5A);
    step();
    check_slot("pri_w2", 1'b1, 1'b1, 16'h0022, 8'h33);
    check("pri_pv0_off", 32'(bus.pix_valid), 32'd0);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'h0104;
    step();
    check_slot("pri_r1", 1'b1, 1'b0, 16'h0104, 8'h00);
    check("pri_count_r1", 32'(bus.wbuf_count), 32'd1);
    bus.rd_req = 1'b0;
    step();
    check_slot("pri_w3", 1'b1, 1'b1, 16'h0023, 8'h34);
    step();
    check("pri_idle", 32'(bus.ram_en), 32'd0);
    check("pri_pv1", 32'(bus.pix_valid), 32'd1);
    check("pri_pix1", 32'(bus.pix_data), 32'hA5);
    step();
    check("pri_pv1_off", 32'(bus.pix_valid), 32'd0);

    // ---- starvation: one entry, 64 consecutive read slots ----
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 16'h0400;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 16'h0060;
    bus.wr_data  = 8'h70;
    step();
    bus.wr_valid = 1'b0;
    check("stv_count", 32'(bus.wbuf_count), 32'd1);
    repeat (63) step();
    check("stv_not_yet", 32'(bus.starve_err), 32'd0);
    bus.err_clr = 1'b1;
    step();
    check("stv_set_wins", 32'(bus.starve_err), 32'd1);
    bus.err_clr = 1'b0;
    repeat (5) step();
    check("stv_sticky", 32'(bus.starve_err), 32'd1);
    check("stv_still_queued", 32'(bus.wbuf_count), 32'd1);
    bus.err_clr = 1'b1;
    bus.rd_req  = 1'b0;
    step();
    bus.err_clr = 1'b0;
    check("stv_cleared", 32'(bus.starve_err), 32'd0);
    check_slot("stv_drain", 1'b1, 1'b1, 16'h0060, 8'h70);
    check("stv_empty", 32'(bus.wbuf_count), 32'd0);

    // ---- reset mid-operation ----
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 16'h0123;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 16'h0077;
    bus.wr_data  = 8'h99;
    step();
    check("mid_count_pre", 32'(bus.wbuf_count), 32'd1);
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    #2 RESET = 1'b1;
    #1;
    check("mid_async_en",    32'(bus.ram_en),     32'd0);
    check("mid_async_count", 32'(bus.wbuf_count), 32'd0);
    check("mid_async_ready", 32'(bus.wr_ready),   32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    step();
    check("mid_pv_a", 32'(bus.pix_valid), 32'd0);
    check("mid_no_drain", 32'(bus.ram_en), 32'd0);
    step();
    check("mid_pv_b", 32'(bus.pix_valid), 32'd0);
    check("mid_count_post", 32'(bus.wbuf_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
